axis_packet_arbiter: RTL

Packet-level round-robin arbiter that shares one AXI-Stream Target port of a tile network interface among NumRequesters AXI-Stream initiators, such as several VIP managers or PE sources inside a tile.
- A grant is locked from the first beat of a packet until its tlast beat; beats of different packets never interleave.
- The output path is a 2-entry skid buffer, so the block sustains full throughput while registering every m_axis output.
- Sits between the PE-side initiators and the NI's s_axis port, in the PE clock domain.

---
 rtl/axis_packet_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Packet-level round-robin arbiter. It merges NumRequesters AXI-Stream
// initiators onto one AXI-Stream target port. A grant is held from the first
// beat of a packet until its tlast beat, so beats of different packets never
// interleave. The output path is a 2-entry skid buffer, so every m_axis output
// comes straight from a register and the block still moves 1 beat/cycle.
//
// Ports
//   clk_axis_i        block clock, rising edge
//   rst_axis_i        synchronous reset, active high
//   s_axis_*          NumRequesters packed upstream streams (slice i = req i)
//   m_axis_*          merged downstream stream (tid/tdest passed unchanged)
//   grant_o           one-hot current grant, zero when idle
//   busy_o            high while a packet is locked
//   pkt_count_o       number of tlast handshakes on m_axis (wraps)
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
  parameter int NumRequesters = 4,
  parameter int TDataWidth    = 64,
  parameter int TIdWidth      = 5,
  parameter int TDestWidth    = 5,
  parameter int PktCountWidth = 32
) (
  input  logic                                clk_axis_i,
  input  logic                                rst_axis_i,
  input  logic [NumRequesters-1:0]            s_axis_tvalid_i,
  output logic [NumRequesters-1:0]            s_axis_tready_o,
  input  logic [NumRequesters*TDataWidth-1:0] s_axis_tdata_i,
  input  logic [NumRequesters-1:0]            s_axis_tlast_i,
  input  logic [NumRequesters*TIdWidth-1:0]   s_axis_tid_i,
  input  logic [NumRequesters*TDestWidth-1:0] s_axis_tdest_i,
  output logic                                m_axis_tvalid_o,
  input  logic                                m_axis_tready_i,
  output logic [TDataWidth-1:0]               m_axis_tdata_o,
  output logic                                m_axis_tlast_o,
  output logic [TIdWidth-1:0]                 m_axis_tid_o,
  output logic [TDestWidth-1:0]               m_axis_tdest_o,
  output logic [NumRequesters-1:0]            grant_o,
  output logic                                busy_o,
  output logic [PktCountWidth-1:0]            pkt_count_o
);

  localparam int IdxW  = $clog2(NumRequesters);
  // Beat layout inside the skid registers: {tlast, tid, tdest, tdata}
  localparam int BeatW = TDataWidth + TDestWidth + TIdWidth + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state_reg, state_next;
  logic [NumRequesters-1:0]   grant_reg, grant_next;
  logic [IdxW-1:0]            grant_idx_reg, grant_idx_next;
  logic [IdxW-1:0]            ptr_reg, ptr_next;

  logic [BeatW-1:0]           head_reg;
  logic [BeatW-1:0]           second_reg;
  logic [1:0]                 count_reg;
  logic [PktCountWidth-1:0]   pkt_count_reg;

  // ---------------------------------------------------------------------------
  // Unpack the per-requester slices
  // ---------------------------------------------------------------------------
  logic [TDataWidth-1:0] in_data [NumRequesters];
  logic [TIdWidth-1:0]   in_id   [NumRequesters];
  logic [TDestWidth-1:0] in_dest [NumRequesters];

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_unpack
    assign in_data[gi] = s_axis_tdata_i[gi*TDataWidth +: TDataWidth];
    assign in_id[gi]   = s_axis_tid_i[gi*TIdWidth +: TIdWidth];
    assign in_dest[gi] = s_axis_tdest_i[gi*TDestWidth +: TDestWidth];
  end

  logic             sel_last;
  logic [BeatW-1:0] in_beat;
  logic             buf_full;
  logic             wr_en;
  logic             rd_en;

  assign sel_last = s_axis_tlast_i[grant_idx_reg];
  assign in_beat  = {sel_last, in_id[grant_idx_reg], in_dest[grant_idx_reg],
                     in_data[grant_idx_reg]};

  assign buf_full        = (count_reg == 2'd2);
  assign s_axis_tready_o = (state_reg == LOCKED && !buf_full) ? grant_reg : '0;
  assign wr_en           = |(s_axis_tvalid_i & s_axis_tready_o);
  assign m_axis_tvalid_o = (count_reg != 2'd0);
  assign rd_en           = m_axis_tvalid_o & m_axis_tready_i;

  // ---------------------------------------------------------------------------
  // Round-robin pick, scanning upward from ptr_reg. The currently granted
  // requester is masked out: its tvalid during the tlast handshake belongs to
  // the beat being consumed, not to a new packet request.
  // ---------------------------------------------------------------------------
  logic [NumRequesters-1:0] arb_req;
  logic                     arb_found;
  logic [IdxW-1:0]          arb_idx;
  logic [IdxW-1:0]          arb_ptr_next;
  logic [IdxW:0]            cand;

  assign arb_req = s_axis_tvalid_i & ~grant_reg;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      cand = {1'b0, ptr_reg} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumRequesters)) begin
        cand = cand - (IdxW+1)'(NumRequesters);
      end
      if (!arb_found && arb_req[cand[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign arb_ptr_next = (arb_idx == IdxW'(NumRequesters - 1)) ? '0
                                                              : arb_idx + IdxW'(1);

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    ptr_next       = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          state_next     = LOCKED;
          grant_next     = NumRequesters'(1) << arb_idx;
          grant_idx_next = arb_idx;
          ptr_next       = arb_ptr_next;
        end
      end
      LOCKED: begin
        // Re-arbitrate in the tlast cycle so a waiting requester follows
        // without a bubble.
        if (wr_en && sel_last) begin
          if (arb_found) begin
            grant_next     = NumRequesters'(1) << arb_idx;
            grant_idx_next = arb_idx;
            ptr_next       = arb_ptr_next;
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      ptr_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      ptr_reg       <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer. head_reg drives m_axis directly; second_reg only
  // fills when the head is stalled. A write while full cannot happen because
  // tready is already low then.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      head_reg   <= '0;
      second_reg <= '0;
      count_reg  <= 2'd0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (wr_en) begin
            head_reg  <= in_beat;
            count_reg <= 2'd1;
          end
        end
        2'd1: begin
          if (wr_en && rd_en) begin
            head_reg <= in_beat;
          end else if (wr_en) begin
            second_reg <= in_beat;
            count_reg  <= 2'd2;
          end else if (rd_en) begin
            count_reg <= 2'd0;
          end
        end
        2'd2: begin
          if (rd_en) begin
            head_reg  <= second_reg;
            count_reg <= 2'd1;
          end
        end
        default: count_reg <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      pkt_count_reg <= '0;
    end else if (rd_en && head_reg[BeatW-1]) begin
      pkt_count_reg <= pkt_count_reg + PktCountWidth'(1);
    end
  end

  assign m_axis_tdata_o = head_reg[TDataWidth-1:0];
  assign m_axis_tdest_o = head_reg[TDataWidth +: TDestWidth];
  assign m_axis_tid_o   = head_reg[TDataWidth+TDestWidth +: TIdWidth];
  assign m_axis_tlast_o = head_reg[BeatW-1];

  assign grant_o     = grant_reg;
  assign busy_o      = (state_reg == LOCKED);
  assign pkt_count_o = pkt_count_reg;

endmodule
